// File: rtl/sha2_core.sv
// Iterative SHA-2 compression engine: SHA-256 (WORD_BITS=32) or SHA-512 (WORD_BITS=64),
// one round per clock, chaining value kept internally across streamed blocks.
module sha2_core #(
  parameter int WORD_BITS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_first,
  input  logic [16*WORD_BITS-1:0]  in_block,
  output logic                     digest_valid,
  output logic [8*WORD_BITS-1:0]   digest
);

  localparam int W = WORD_BITS;
  localparam bit IS64 = (W == 64);
  localparam int R = IS64 ? 80 : 64;
  localparam logic [6:0] LAST_ROUND = 7'(R - 1);

  localparam int unsigned BS0_A = IS64 ? 28 : 2;
  localparam int unsigned BS0_B = IS64 ? 34 : 13;
  localparam int unsigned BS0_C = IS64 ? 39 : 22;
  localparam int unsigned BS1_A = IS64 ? 14 : 6;
  localparam int unsigned BS1_B = IS64 ? 18 : 11;
  localparam int unsigned BS1_C = IS64 ? 41 : 25;
  localparam int unsigned SS0_A = IS64 ? 1  : 7;
  localparam int unsigned SS0_B = IS64 ? 8  : 18;
  localparam int unsigned SS0_C = IS64 ? 7  : 3;
  localparam int unsigned SS1_A = IS64 ? 19 : 17;
  localparam int unsigned SS1_B = IS64 ? 61 : 19;
  localparam int unsigned SS1_C = IS64 ? 6  : 10;

  if (!(W == 32 || W == 64)) begin : g_bad_width
    $error("sha2_core: WORD_BITS must be 32 or 64");
  end

  // SHA-256 constants and IV are the upper 32 bits of the SHA-512 ones, so one table serves both.
  localparam logic [63:0] K64 [0:79] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [63:0] IV64 [0:7] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  typedef enum logic [1:0] {ST_IDLE, ST_ROUND, ST_FINAL} state_t;

  function automatic logic [W-1:0] ror(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [W-1:0] big_sigma0(input logic [W-1:0] x);
    return ror(x, BS0_A) ^ ror(x, BS0_B) ^ ror(x, BS0_C);
  endfunction

  function automatic logic [W-1:0] big_sigma1(input logic [W-1:0] x);
    return ror(x, BS1_A) ^ ror(x, BS1_B) ^ ror(x, BS1_C);
  endfunction

  function automatic logic [W-1:0] small_sigma0(input logic [W-1:0] x);
    return ror(x, SS0_A) ^ ror(x, SS0_B) ^ (x >> SS0_C);
  endfunction

  function automatic logic [W-1:0] small_sigma1(input logic [W-1:0] x);
    return ror(x, SS1_A) ^ ror(x, SS1_B) ^ (x >> SS1_C);
  endfunction

  state_t     state_q, state_d;
  logic [6:0] round_q, round_d;
  logic       first_q, first_d;
  logic       dv_q, dv_d;
  logic [W-1:0] sched_q [16];
  logic [W-1:0] sched_d [16];
  logic [W-1:0] work_q [8];
  logic [W-1:0] work_d [8];
  logic [W-1:0] h_q [8];
  logic [W-1:0] h_d [8];
  logic [W-1:0] iv [8];
  logic [W-1:0] k_t, t1, t2, w_next;

  for (genvar g = 0; g < 8; g++) begin : g_words
    assign iv[g] = IV64[g][63 -: W];
    assign digest[(8-g)*W-1 -: W] = h_q[g];
  end

  assign k_t    = K64[round_q][63 -: W];
  assign t1     = work_q[7] + big_sigma1(work_q[4])
                + ((work_q[4] & work_q[5]) ^ (~work_q[4] & work_q[6])) + k_t + sched_q[0];
  assign t2     = big_sigma0(work_q[0])
                + ((work_q[0] & work_q[1]) ^ (work_q[0] & work_q[2]) ^ (work_q[1] & work_q[2]));
  // sched_q[0] is W[t], so W[t+16] draws on W[t+14], W[t+9], W[t+1] and W[t].
  assign w_next = small_sigma1(sched_q[14]) + sched_q[9] + small_sigma0(sched_q[1]) + sched_q[0];

  assign in_ready     = (state_q == ST_IDLE) && rst_n;
  assign digest_valid = dv_q;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    first_d = first_q;
    dv_d    = 1'b0;
    sched_d = sched_q;
    work_d  = work_q;
    h_d     = h_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < 16; i++) sched_d[i] = in_block[(16-i)*W-1 -: W];
          for (int i = 0; i < 8; i++) work_d[i] = in_first ? iv[i] : h_q[i];
          first_d = in_first;
          round_d = 7'd0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        for (int i = 0; i < 15; i++) sched_d[i] = sched_q[i+1];
        sched_d[15] = w_next;
        work_d[0] = t1 + t2;
        work_d[1] = work_q[0];
        work_d[2] = work_q[1];
        work_d[3] = work_q[2];
        work_d[4] = work_q[3] + t1;
        work_d[5] = work_q[4];
        work_d[6] = work_q[5];
        work_d[7] = work_q[6];
        round_d   = round_q + 7'd1;
        if (round_q == LAST_ROUND) state_d = ST_FINAL;
      end
      ST_FINAL: begin
        for (int i = 0; i < 8; i++) h_d[i] = (first_q ? iv[i] : h_q[i]) + work_q[i];
        dv_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset discards any block in flight and restores the chaining value to the IV.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      round_q <= 7'd0;
      first_q <= 1'b0;
      dv_q    <= 1'b0;
      h_q     <= iv;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      first_q <= first_d;
      dv_q    <= dv_d;
      h_q     <= h_d;
    end
  end

  always_ff @(posedge clk) begin
    sched_q <= sched_d;
    work_q  <= work_d;
  end

endmodule
